exec_unit: RTL

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 63 ++++++
 rtl/exec_unit_muldiv.sv | 146 ++++++++++++++
 rtl/exec_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/exec_unit_pkg.sv
// Shared types for the execution unit: ALU control codes, M-op codes, FSM states.
// Also holds the base-op decoder so every consumer sees one decode table.
// No logic state lives here.
package exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_t;

  // Encoding matches funct3 of the M-extension instructions.
  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } mop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // Base-op decode; sub in the funct3=000 slot only for R-type with bit 30 set.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op,
                                           input logic [2:0] funct3,
                                           input logic       funct7b5,
                                           input logic       opb5);
    alu_ctrl_t ctrl;
    ctrl = ALU_ADD;
    if (alu_op == 2'b00) begin
      ctrl = ALU_ADD;
    end else if (alu_op == 2'b01) begin
      ctrl = ALU_SUB;
    end else begin
      case (funct3)
        3'b000:  ctrl = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
        3'b001:  ctrl = ALU_SLL;
        3'b010:  ctrl = ALU_SLT;
        3'b011:  ctrl = ALU_SLTU;
        3'b100:  ctrl = ALU_XOR;
        3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  ctrl = ALU_OR;
        default: ctrl = ALU_AND;
      endcase
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/exec_unit_muldiv.sv
// Iterative multiply/divide: magnitude shift-add / restoring divide, one bit per cycle.
// Latency: XLEN cycles in CALC plus one FIX cycle; o_done is high during FIX.
// No backpressure: the caller must not start while o_busy; only built with EXEC_MULDIV_EN.
`ifdef EXEC_MULDIV_EN
module muldiv_iter
  import exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int CW = $clog2(XLEN);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  mop_t            r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_bmag;
  logic [XLEN-1:0] r_a_raw;
  logic            r_neg_a;
  logic            r_neg_res;
  logic            r_bzero;

  mop_t            w_op;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic [XLEN:0]   w_msum;
  logic [XLEN:0]   w_dsh;
  logic [XLEN:0]   w_ddiff;
  logic            w_dge;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;

  // Operand signedness: mulhsu treats only a as signed; *u ops are fully unsigned.
  assign w_op    = mop_t'(i_op);
  assign w_a_sgn = (w_op == M_MUL) || (w_op == M_MULH) || (w_op == M_MULHSU) ||
                   (w_op == M_DIV) || (w_op == M_REM);
  assign w_b_sgn = (w_op == M_MUL) || (w_op == M_MULH) ||
                   (w_op == M_DIV) || (w_op == M_REM);
  assign w_neg_a = w_a_sgn & i_a[XLEN-1];
  assign w_neg_b = w_b_sgn & i_b[XLEN-1];
  assign w_amag  = w_neg_a ? (~i_a + 1'b1) : i_a;
  assign w_bmag  = w_neg_b ? (~i_b + 1'b1) : i_b;

  // One step of shift-add multiply and of restoring divide.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bmag} : {(XLEN+1){1'b0}});
  assign w_dsh   = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff = w_dsh - {1'b0, r_bmag};
  assign w_dge   = ~w_ddiff[XLEN];

  // Sign correction applied in FIX; divide-by-zero bypasses the magnitude result.
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = r_neg_res ? (~r_lo + 1'b1) : r_lo;
  assign w_rem      = r_neg_a ? (~r_hi + 1'b1) : r_hi;

  // Select the final result for the captured op.
  always_comb begin
    o_res = '0;
    case (r_op)
      M_MUL:                     o_res = w_prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: o_res = w_prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             o_res = r_bzero ? {XLEN{1'b1}} : w_quo;
      default:                   o_res = r_bzero ? r_a_raw : w_rem;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_CALC;
      ST_CALC: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(XLEN-1)) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture magnitudes at start, then iterate one bit per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op      <= M_MUL;
      r_hi      <= '0;
      r_lo      <= '0;
      r_bmag    <= '0;
      r_a_raw   <= '0;
      r_neg_a   <= 1'b0;
      r_neg_res <= 1'b0;
      r_bzero   <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_cnt     <= '0;
      r_op      <= w_op;
      r_hi      <= '0;
      r_lo      <= w_amag;
      r_bmag    <= w_bmag;
      r_a_raw   <= i_a;
      r_neg_a   <= w_neg_a;
      r_neg_res <= w_neg_a ^ w_neg_b;
      r_bzero   <= (i_b == '0);
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op[2]) begin
        r_hi <= w_dge ? w_ddiff[XLEN-1:0] : w_dsh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_dge};
      end else begin
        r_hi <= w_msum[XLEN:1];
        r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
      end
    end
  end

endmodule
`endif

// File: rtl/exec_unit.sv
// Execution unit: base ALU (1-cycle) plus optional iterative M-ops when EXEC_MULDIV_EN is defined.
// Latency: base ops 1 cycle; M ops XLEN+2 cycles.
// Backpressure: result held until out_ready; in_ready = idle & (!out_valid | out_ready).
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  alu_ctrl_t       w_ctrl;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_accept;
  logic            w_is_m;
  logic            w_md_busy;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_res;

  assign w_ctrl   = alu_decode(ALUOp, funct3, funct7b5, opb5);
  assign w_shamt  = b[SHW-1:0];
  assign in_ready = ~w_md_busy & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready;

`ifdef EXEC_MULDIV_EN
  assign w_is_m = ALUOp[1] & opb5 & funct7b0;

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_accept & w_is_m),
    .i_op   (funct3),
    .i_a    (a),
    .i_b    (b),
    .o_busy (w_md_busy),
    .o_done (w_md_done),
    .o_res  (w_md_res)
  );
`else
  logic w_unused_f7b0;
  assign w_unused_f7b0 = funct7b0;
  assign w_is_m        = 1'b0;
  assign w_md_busy     = 1'b0;
  assign w_md_done     = 1'b0;
  assign w_md_res      = '0;
`endif

  // Base ALU operating directly on the live request operands.
  always_comb begin
    w_alu = '0;
    case (w_ctrl)
      ALU_ADD:  w_alu = a + b;
      ALU_SUB:  w_alu = a - b;
      ALU_AND:  w_alu = a & b;
      ALU_OR:   w_alu = a | b;
      ALU_XOR:  w_alu = a ^ b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  w_alu = a << w_shamt;
      ALU_SRL:  w_alu = a >> w_shamt;
      ALU_SRA:  w_alu = $signed(a) >>> w_shamt;
      default:  w_alu = '0;
    endcase
  end

  // Output register: loads on M-op completion or base-op accept, clears on consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_md_done) begin
      r_valid  <= 1'b1;
      r_result <= w_md_res;
      r_zero   <= (w_md_res == '0);
    end else if (w_accept && !w_is_m) begin
      r_valid  <= 1'b1;
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
    end else if (r_valid && out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign busy      = w_md_busy;

endmodule
